// File: rtl/rob_multi_commit_if.sv
// rob_multi_commit_if: issue, writeback, lookup and commit bundle of the reorder buffer
interface rob_multi_commit_if #(
    parameter int IDX_BIT   = 4,
    parameter int CDB_PORTS = 2,
    parameter int COMMIT_W  = 2
);
    logic                         rdy_in;
    logic                         inst_req;
    logic [1:0]                   inst_kind;
    logic [4:0]                   inst_rd;
    logic [31:0]                  inst_pc;
    logic [31:0]                  inst_imm;
    logic                         inst_pred;
    logic [IDX_BIT-1:0]           alloc_id_out;
    logic                         full_out;
    logic                         empty_out;
    logic [IDX_BIT-1:0]           head_out;
    logic [CDB_PORTS-1:0]         wb_valid;
    logic [CDB_PORTS*IDX_BIT-1:0] wb_id;
    logic [CDB_PORTS*32-1:0]      wb_val;
    logic [2*IDX_BIT-1:0]         q_id;
    logic [1:0]                   q_ready;
    logic [63:0]                  q_val;
    logic [COMMIT_W-1:0]          commit_valid;
    logic [COMMIT_W*5-1:0]        commit_rd;
    logic [COMMIT_W*32-1:0]       commit_val;
    logic [COMMIT_W*IDX_BIT-1:0]  commit_id;
    logic                         flush_out;
    logic [31:0]                  flush_pc;
    logic                         jalr_ready;
    logic [31:0]                  jalr_addr;
    logic                         br_ready;
    logic                         br_taken;
    logic                         br_correct;
    logic [31:0]                  stat_commits;
    logic [31:0]                  stat_mispred;

    modport master (
        output rdy_in, inst_req, inst_kind, inst_rd, inst_pc, inst_imm, inst_pred,
        output wb_valid, wb_id, wb_val, q_id,
        input  alloc_id_out, full_out, empty_out, head_out, q_ready, q_val,
        input  commit_valid, commit_rd, commit_val, commit_id,
        input  flush_out, flush_pc, jalr_ready, jalr_addr, br_ready, br_taken, br_correct,
        input  stat_commits, stat_mispred
    );

    modport slave (
        input  rdy_in, inst_req, inst_kind, inst_rd, inst_pc, inst_imm, inst_pred,
        input  wb_valid, wb_id, wb_val, q_id,
        output alloc_id_out, full_out, empty_out, head_out, q_ready, q_val,
        output commit_valid, commit_rd, commit_val, commit_id,
        output flush_out, flush_pc, jalr_ready, jalr_addr, br_ready, br_taken, br_correct,
        output stat_commits, stat_mispred
    );
endinterface

// File: rtl/rob_multi_commit.sv
// rob_multi_commit: multi-retire reorder buffer with CDB bypass lookup; ROB_STATS_EN adds commit/mispredict counters
module rob_multi_commit #(
    parameter int ROB_DEPTH = 16,
    parameter int IDX_BIT   = 4,
    parameter int CDB_PORTS = 2,
    parameter int COMMIT_W  = 2
) (
    input logic                clk_in,
    input logic                rst_in,
    rob_multi_commit_if.slave  bus
);
    logic [ROB_DEPTH-1:0] busy;
    logic [ROB_DEPTH-1:0] ready;
    logic [ROB_DEPTH-1:0] pred;
    logic [1:0]           kind [ROB_DEPTH];
    logic [4:0]           rd   [ROB_DEPTH];
    logic [31:0]          pc   [ROB_DEPTH];
    logic [31:0]          imm  [ROB_DEPTH];
    logic [31:0]          res  [ROB_DEPTH];
    logic [IDX_BIT-1:0]   head;
    logic [IDX_BIT-1:0]   tail;
    logic [IDX_BIT:0]     count;
    logic                 full;
    logic                 do_alloc;

    logic [COMMIT_W-1:0]         ret;
    logic [IDX_BIT-1:0]          slot [COMMIT_W];
    logic [IDX_BIT:0]            n_ret;
    logic                        go;
    logic [COMMIT_W*5-1:0]       nx_rd;
    logic [COMMIT_W*32-1:0]      nx_val;
    logic [COMMIT_W*IDX_BIT-1:0] nx_id;
    logic                        nx_br;
    logic                        nx_bt;
    logic                        nx_bc;
    logic                        nx_jr;
    logic                        nx_flush;
    logic [31:0]                 nx_fpc;
    logic [31:0]                 nx_ja;

    logic [IDX_BIT-1:0] qi [2];
    logic [1:0]         byp;
    logic [31:0]        bv [2];

    assign full             = count == (IDX_BIT+1)'(ROB_DEPTH);
    assign do_alloc         = bus.inst_req && !full;
    assign bus.full_out     = full;
    assign bus.empty_out    = count == '0;
    assign bus.head_out     = head;
    assign bus.alloc_id_out = tail;

    // find the in-order run of ready entries at head; a branch or JALR closes the group
    always_comb begin
        go    = 1'b1;
        n_ret = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            slot[k] = head + IDX_BIT'(k);
            ret[k]  = go && busy[slot[k]] && ready[slot[k]];
            go      = ret[k] && !kind[slot[k]][1];
            n_ret   = n_ret + (IDX_BIT+1)'(ret[k]);
        end
    end

    // build the commit payload and resolve the branch or JALR that ends the group
    always_comb begin
        nx_rd  = '0;
        nx_val = '0;
        nx_id  = '0;
        nx_br  = 1'b0;
        nx_bt  = 1'b0;
        nx_bc  = 1'b0;
        nx_jr  = 1'b0;
        nx_fpc = '0;
        nx_ja  = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            if (ret[k]) begin
                nx_id[k*IDX_BIT +: IDX_BIT] = slot[k];
                nx_rd[k*5 +: 5]   = (kind[slot[k]] == 2'd0 || kind[slot[k]] == 2'd3) ? rd[slot[k]] : 5'd0;
                nx_val[k*32 +: 32] = kind[slot[k]] == 2'd0 ? res[slot[k]] :
                                     kind[slot[k]] == 2'd3 ? pc[slot[k]] + 32'd4 : 32'd0;
                if (kind[slot[k]] == 2'd2) begin
                    nx_br  = 1'b1;
                    nx_bt  = res[slot[k]][0];
                    nx_bc  = res[slot[k]][0] == pred[slot[k]];
                    nx_fpc = res[slot[k]][0] ? pc[slot[k]] + imm[slot[k]] : pc[slot[k]] + 32'd4;
                end
                if (kind[slot[k]] == 2'd3) begin
                    nx_jr = 1'b1;
                    nx_ja = res[slot[k]];
                end
            end
        end
        nx_flush = nx_br && !nx_bc;
    end

    // operand lookup: a same-cycle CDB hit (highest port) overrides the stored result
    always_comb begin
        bus.q_ready = '0;
        bus.q_val   = '0;
        for (int j = 0; j < 2; j++) begin
            qi[j]  = bus.q_id[j*IDX_BIT +: IDX_BIT];
            byp[j] = 1'b0;
            bv[j]  = res[qi[j]];
            for (int p = 0; p < CDB_PORTS; p++) begin
                if (bus.wb_valid[p] && bus.wb_id[p*IDX_BIT +: IDX_BIT] == qi[j]) begin
                    byp[j] = 1'b1;
                    bv[j]  = bus.wb_val[p*32 +: 32];
                end
            end
            bus.q_ready[j]       = busy[qi[j]] && (ready[qi[j]] || byp[j]);
            bus.q_val[j*32 +: 32] = busy[qi[j]] ? bv[j] : 32'd0;
        end
    end

    // entry state, pointers and registered commit outputs; a flush pulse empties the buffer next edge
    always_ff @(posedge clk_in) begin
        if (rst_in || bus.flush_out) begin
            busy             <= '0;
            ready            <= '0;
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            bus.commit_valid <= '0;
            bus.commit_rd    <= '0;
            bus.commit_val   <= '0;
            bus.commit_id    <= '0;
            bus.flush_out    <= 1'b0;
            bus.flush_pc     <= '0;
            bus.jalr_ready   <= 1'b0;
            bus.jalr_addr    <= '0;
            bus.br_ready     <= 1'b0;
            bus.br_taken     <= 1'b0;
            bus.br_correct   <= 1'b0;
        end else if (bus.rdy_in) begin
            for (int p = 0; p < CDB_PORTS; p++) begin
                if (bus.wb_valid[p] && busy[bus.wb_id[p*IDX_BIT +: IDX_BIT]]) begin
                    ready[bus.wb_id[p*IDX_BIT +: IDX_BIT]] <= 1'b1;
                    res[bus.wb_id[p*IDX_BIT +: IDX_BIT]]   <= bus.wb_val[p*32 +: 32];
                end
            end
            if (do_alloc) begin
                busy[tail]  <= 1'b1;
                ready[tail] <= 1'b0;
                kind[tail]  <= bus.inst_kind;
                rd[tail]    <= bus.inst_rd;
                pc[tail]    <= bus.inst_pc;
                imm[tail]   <= bus.inst_imm;
                pred[tail]  <= bus.inst_pred;
                res[tail]   <= '0;
            end
            for (int k = 0; k < COMMIT_W; k++) begin
                if (ret[k]) busy[slot[k]] <= 1'b0;
            end
            head             <= head + n_ret[IDX_BIT-1:0];
            tail             <= tail + IDX_BIT'(do_alloc);
            count            <= count + (IDX_BIT+1)'(do_alloc) - n_ret;
            bus.commit_valid <= ret;
            bus.commit_rd    <= nx_rd;
            bus.commit_val   <= nx_val;
            bus.commit_id    <= nx_id;
            bus.flush_out    <= nx_flush;
            bus.flush_pc     <= nx_flush ? nx_fpc : 32'd0;
            bus.jalr_ready   <= nx_jr;
            bus.jalr_addr    <= nx_ja;
            bus.br_ready     <= nx_br;
            bus.br_taken     <= nx_bt;
            bus.br_correct   <= nx_bc;
        end
    end

`ifdef ROB_STATS_EN
    logic [31:0] stat_c;
    logic [31:0] stat_m;

    // running totals survive flushes; only rst_in clears them
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stat_c <= '0;
            stat_m <= '0;
        end else if (!bus.flush_out && bus.rdy_in) begin
            stat_c <= stat_c + 32'(n_ret);
            stat_m <= stat_m + 32'(nx_flush);
        end
    end

    assign bus.stat_commits = stat_c;
    assign bus.stat_mispred = stat_m;
`else
    assign bus.stat_commits = '0;
    assign bus.stat_mispred = '0;
`endif
endmodule

// File: tb/tb_rob_multi_commit.sv
// tb_rob_multi_commit: queue-model checked directed bench for the reorder buffer
module tb_rob_multi_commit;
    logic clk;
    logic rst;
    logic chk_en;
    int   checks;
    int   errors;

    rob_multi_commit_if #(.IDX_BIT(4), .CDB_PORTS(3), .COMMIT_W(2)) b();

    rob_multi_commit #(.ROB_DEPTH(16), .IDX_BIT(4), .CDB_PORTS(3), .COMMIT_W(2)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus(b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] res;
        logic        pred;
        logic        rdy;
    } ent_t;

    ent_t        mq[$];
    logic [3:0]  m_head;
    logic [3:0]  m_tail;
    logic [1:0]  e_valid;
    logic [9:0]  e_rd;
    logic [63:0] e_val;
    logic [7:0]  e_id;
    logic [1:0]  e_kind [2];
    logic        e_flush, e_jr, e_br, e_bt, e_bc;
    logic [31:0] e_fpc, e_ja, e_sc, e_sm;
    logic [3:0]  l_id;
    logic        l_found, l_byp, l_rdy;
    logic [31:0] l_res, l_bv;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clr_exp();
        e_valid = '0; e_rd = '0; e_val = '0; e_id = '0;
        e_kind[0] = '0; e_kind[1] = '0;
        e_flush = 0; e_jr = 0; e_br = 0; e_bt = 0; e_bc = 0;
        e_fpc = '0; e_ja = '0;
    endtask

    // program-order queue model: retire from the front, writebacks by id, allocate at the back
    always @(posedge clk) begin
        if (rst || e_flush) begin
            mq.delete();
            m_head = '0;
            m_tail = '0;
            if (rst) begin
                e_sc = '0;
                e_sm = '0;
            end
            clr_exp();
        end else if (b.rdy_in) begin
            int   n;
            int   sz;
            ent_t e;
            sz = mq.size();
            n  = 0;
            clr_exp();
            for (int k = 0; k < 2; k++) begin
                if (k >= mq.size() || !mq[k].rdy) break;
                e = mq[k];
                e_valid[k] = 1'b1;
                e_id[k*4 +: 4] = e.id;
                e_kind[k] = e.kind;
                if (e.kind == 0) begin
                    e_rd[k*5 +: 5] = e.rd;
                    e_val[k*32 +: 32] = e.res;
                end else if (e.kind == 3) begin
                    e_rd[k*5 +: 5] = e.rd;
                    e_val[k*32 +: 32] = e.pc + 32'd4;
                    e_jr = 1'b1;
                    e_ja = e.res;
                end else if (e.kind == 2) begin
                    e_br = 1'b1;
                    e_bt = e.res[0];
                    e_bc = e.res[0] == e.pred;
                    e_flush = !e_bc;
                    if (e_flush) e_fpc = e.res[0] ? e.pc + e.imm : e.pc + 32'd4;
                end
                n++;
                if (e.kind >= 2) break;
            end
            for (int p = 0; p < 3; p++) begin
                if (b.wb_valid[p]) begin
                    foreach (mq[i]) begin
                        if (mq[i].id == b.wb_id[p*4 +: 4]) begin
                            mq[i].rdy = 1'b1;
                            mq[i].res = b.wb_val[p*32 +: 32];
                        end
                    end
                end
            end
            repeat (n) void'(mq.pop_front());
            if (b.inst_req && sz < 16) begin
                e.id = m_tail; e.kind = b.inst_kind; e.rd = b.inst_rd; e.pc = b.inst_pc;
                e.imm = b.inst_imm; e.pred = b.inst_pred; e.res = '0; e.rdy = 1'b0;
                mq.push_back(e);
                m_tail = m_tail + 4'd1;
            end
            m_head = m_head + 4'(n);
            e_sc = e_sc + 32'(n);
            e_sm = e_sm + 32'(e_flush);
        end
    end

    // compare every output against the model once per cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("full", b.full_out, mq.size() == 16);
            chk("empty", b.empty_out, mq.size() == 0);
            chk("head", b.head_out, m_head);
            chk("alloc_id", b.alloc_id_out, m_tail);
            chk("commit_valid", b.commit_valid, e_valid);
            chk("commit_rd", b.commit_rd, e_rd);
            chk("commit_id", b.commit_id, e_id);
            for (int k = 0; k < 2; k++)
                if (e_valid[k] && (e_kind[k] == 0 || e_kind[k] == 3))
                    chk("commit_val", b.commit_val[k*32 +: 32], e_val[k*32 +: 32]);
            chk("flush", b.flush_out, e_flush);
            chk("flush_pc", b.flush_pc, e_fpc);
            chk("jalr_ready", b.jalr_ready, e_jr);
            chk("jalr_addr", b.jalr_addr, e_ja);
            chk("br_ready", b.br_ready, e_br);
            chk("br_taken", b.br_taken, e_bt);
            chk("br_correct", b.br_correct, e_bc);
`ifdef ROB_STATS_EN
            chk("stat_commits", b.stat_commits, e_sc);
            chk("stat_mispred", b.stat_mispred, e_sm);
`else
            chk("stat_commits", b.stat_commits, 0);
            chk("stat_mispred", b.stat_mispred, 0);
`endif
            for (int j = 0; j < 2; j++) begin
                l_id = b.q_id[j*4 +: 4];
                l_found = 0; l_rdy = 0; l_res = '0; l_byp = 0; l_bv = '0;
                foreach (mq[i]) if (mq[i].id == l_id) begin
                    l_found = 1; l_rdy = mq[i].rdy; l_res = mq[i].res;
                end
                for (int p = 0; p < 3; p++)
                    if (b.wb_valid[p] && b.wb_id[p*4 +: 4] == l_id) begin
                        l_byp = 1; l_bv = b.wb_val[p*32 +: 32];
                    end
                chk("q_ready", b.q_ready[j], l_found && (l_rdy || l_byp));
                chk("q_val", b.q_val[j*32 +: 32], !l_found ? 32'd0 : l_byp ? l_bv : l_res);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic ins(input logic [1:0] k, input logic [4:0] r, input logic [31:0] p,
                       input logic [31:0] im, input logic pr);
        b.inst_req = 1; b.inst_kind = k; b.inst_rd = r; b.inst_pc = p; b.inst_imm = im; b.inst_pred = pr;
        tick();
        b.inst_req = 0;
    endtask

    task automatic wbp(input int p, input logic [3:0] id, input logic [31:0] v);
        b.wb_valid[p] = 1'b1;
        b.wb_id[p*4 +: 4] = id;
        b.wb_val[p*32 +: 32] = v;
    endtask

    task automatic wb_clr();
        b.wb_valid = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; errors = 0; chk_en = 0;
        rst = 1; b.rdy_in = 1; b.inst_req = 0; b.inst_kind = 0; b.inst_rd = 0; b.inst_pc = 0;
        b.inst_imm = 0; b.inst_pred = 0; b.wb_valid = 0; b.wb_id = 0; b.wb_val = 0; b.q_id = 0;
        e_flush = 0; e_sc = 0; e_sm = 0;
        tick(); tick();
        chk_en = 1; rst = 0;
        at_neg();
        chk("rst_empty", b.empty_out, 1);
        chk("rst_head", b.head_out, 0);
        chk("rst_valid", b.commit_valid, 0);

        ins(0, 5, 32'h0, 0, 0); ins(0, 6, 32'h4, 0, 0); ins(0, 7, 32'h8, 0, 0);
        wbp(0, 0, 10); wbp(1, 1, 20); wbp(2, 2, 30);
        tick(); wb_clr();
        at_neg(); chk("t1_wb_no_retire", b.commit_valid, 0);
        tick(); at_neg();
        chk("t1_valid2", b.commit_valid, 2'b11);
        chk("t1_rd2", b.commit_rd, 10'h0C5);
        chk("t1_val2", b.commit_val, 64'h00000014_0000000A);
        tick(); at_neg();
        chk("t1_valid1", b.commit_valid, 2'b01);
        chk("t1_rd1", b.commit_rd, 10'd7);
        chk("t1_val1", b.commit_val[31:0], 32'd30);
        chk("t1_head", b.head_out, 3);

        do_reset();
        for (int i = 0; i < 16; i++) ins(0, 5'(i + 1), 32'(4 * i), 0, 0);
        at_neg(); chk("t2_full", b.full_out, 1); chk("t2_alloc", b.alloc_id_out, 0);
        ins(0, 31, 32'h999, 0, 0);
        at_neg(); chk("t2_drop_alloc", b.alloc_id_out, 0); chk("t2_drop_head", b.head_out, 0);
        wbp(0, 0, 100); wbp(1, 1, 101);
        tick(); wb_clr(); tick();
        at_neg(); chk("t2_ret", b.commit_valid, 2'b11); chk("t2_notfull", b.full_out, 0);
        chk("t2_head", b.head_out, 2);
        ins(0, 2, 0, 0, 0); ins(0, 3, 0, 0, 0);
        at_neg(); chk("t2_refull", b.full_out, 1); chk("t2_alloc2", b.alloc_id_out, 2);

        do_reset();
        ins(2, 0, 32'h100, 32'h40, 0); ins(0, 3, 32'h104, 0, 0);
        wbp(0, 0, 1); wbp(1, 1, 9);
        tick(); wb_clr(); tick();
        at_neg();
        chk("t3_br_ready", b.br_ready, 1); chk("t3_br_correct", b.br_correct, 0);
        chk("t3_flush", b.flush_out, 1); chk("t3_flush_pc", b.flush_pc, 32'h140);
        chk("t3_group", b.commit_valid, 2'b01);
        tick(); at_neg();
        chk("t3_clr_head", b.head_out, 0); chk("t3_clr_tail", b.alloc_id_out, 0);
        chk("t3_clr_empty", b.empty_out, 1);
        ins(2, 0, 32'h180, 32'h10, 1); wbp(2, 0, 1); tick(); wb_clr(); tick();
        at_neg(); chk("t3_ok_correct", b.br_correct, 1); chk("t3_ok_noflush", b.flush_out, 0);
        ins(2, 0, 32'hFFFF_FFF0, 32'h20, 0); wbp(0, 1, 1); tick(); wb_clr(); tick();
        at_neg(); chk("t3_wrap_pc", b.flush_pc, 32'h10);
        tick();
        ins(2, 0, 32'h300, 32'h8, 1); wbp(0, 0, 0); tick(); wb_clr(); tick();
        at_neg(); chk("t3_nt_pc", b.flush_pc, 32'h304); chk("t3_nt_taken", b.br_taken, 0);
        tick();

        ins(3, 1, 32'h200, 0, 0); ins(0, 9, 32'h204, 0, 0);
        wbp(0, 0, 32'h3000); wbp(1, 1, 32'h55);
        tick(); wb_clr(); tick();
        at_neg();
        chk("t4_jalr", b.jalr_ready, 1); chk("t4_addr", b.jalr_addr, 32'h3000);
        chk("t4_link", b.commit_val[31:0], 32'h204); chk("t4_only", b.commit_valid, 2'b01);
        tick(); at_neg();
        chk("t4_young_rd", b.commit_rd, 10'd9); chk("t4_young_id", b.commit_id[3:0], 1);

        ins(0, 10, 0, 0, 0); ins(0, 11, 0, 0, 0);
        b.q_id = {4'd2, 4'd3}; wbp(1, 3, 32'hABCD);
        at_neg(); chk("t5_byp_rdy", b.q_ready, 2'b01); chk("t5_byp_val", b.q_val, 64'hABCD);
        tick(); wb_clr(); wbp(0, 2, 32'h77); wbp(2, 2, 32'h99);
        at_neg(); chk("t5_hi_rdy", b.q_ready, 2'b11); chk("t5_hi_val", b.q_val, 64'h00000099_0000ABCD);
        tick(); wb_clr();
        at_neg(); chk("t5_hold", b.commit_valid, 0);
        tick(); b.q_id = {4'd15, 4'd3};
        at_neg();
        chk("t5_ret_rd", b.commit_rd, 10'h16A); chk("t5_ret_val", b.commit_val, 64'h0000ABCD_00000099);
        chk("t5_nb_rdy", b.q_ready, 0); chk("t5_nb_val", b.q_val, 0);

        ins(0, 12, 0, 0, 0); ins(0, 13, 0, 0, 0);
        wbp(0, 4, 32'h44); wbp(1, 5, 32'h55);
        tick(); wb_clr();
        b.rdy_in = 0; b.inst_req = 1; b.inst_rd = 14;
        for (int i = 0; i < 3; i++) begin
            tick(); at_neg();
            chk("t6_no_pulse", b.commit_valid, 0); chk("t6_head", b.head_out, 4);
            chk("t6_tail", b.alloc_id_out, 6);
        end
        b.rdy_in = 1; b.inst_req = 0;
        tick(); at_neg();
        chk("t6_resume", b.commit_valid, 2'b11); chk("t6_val", b.commit_val, 64'h00000055_00000044);
        chk("t6_head2", b.head_out, 6);
        tick(); at_neg();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rob_multi_commit.md
Name: rob_multi_commit

Overview:
Parametrised reorder buffer for the out-of-order core. It allocates one entry per cycle from the issue stage and accepts results from CDB_PORTS writeback ports. It retires up to COMMIT_W ready entries per cycle in program order. It resolves branch misprediction and JALR redirection at commit, and offers two combinational operand-lookup ports with CDB bypass for the issue stage.

Parameters:
ROB_DEPTH, 16, number of entries; must be a power of two, at least 4.
IDX_BIT, 4, width of a ROB index; equals log2(ROB_DEPTH).
CDB_PORTS, 2, number of writeback ports.
COMMIT_W, 2, maximum retirements per cycle; must be at least 1 and at most ROB_DEPTH.

Ports:
clk_in  in  1  clock; all state changes on the rising edge.
rst_in  in  1  synchronous reset, active-high.
rdy_in  in  1  when low, all state and registered outputs hold.
inst_req  in  1  allocate one entry at tail.
inst_kind  in  2  entry kind: 0 = result-writing (ALU/load/JAL/LUI/AUIPC), 1 = store, 2 = branch, 3 = JALR.
inst_rd  in  5  destination register; 0 means no register write.
inst_pc  in  32  instruction address.
inst_imm  in  32  branch offset.
inst_pred  in  1  predicted branch taken.
alloc_id_out  out  IDX_BIT  current tail (ID given to inst_req this cycle).
full_out  out  1  combinational; high when count == ROB_DEPTH.
empty_out  out  1  combinational; high when count == 0.
head_out  out  IDX_BIT  current head.
wb_valid  in  CDB_PORTS  per-port writeback strobe.
wb_id  in  CDB_PORTS*IDX_BIT  packed writeback IDs; port p uses bits [p*IDX_BIT +: IDX_BIT].
wb_val  in  CDB_PORTS*32  packed results; for a branch, bit 0 = taken; for JALR, the target.
q_id  in  2*IDX_BIT  two lookup IDs.
q_ready  out  2  combinational; entry result available.
q_val  out  64  combinational; lookup values.
commit_valid  out  COMMIT_W  registered; per-slot retire pulse.
commit_rd  out  COMMIT_W*5  registered; 0 for stores and branches.
commit_val  out  COMMIT_W*32  registered; value to write to rd.
commit_id  out  COMMIT_W*IDX_BIT  registered; retired entry IDs.
flush_out  out  1  registered; one-cycle misprediction pulse.
flush_pc  out  32  registered; redirect target.
jalr_ready  out  1  registered; JALR retire pulse.
jalr_addr  out  32  registered; JALR target.
br_ready  out  1  registered; branch retire pulse.
br_taken  out  1  registered; actual branch outcome.
br_correct  out  1  registered; prediction matched the outcome.
stat_commits  out  32  see Optional Feature.
stat_mispred  out  32  see Optional Feature.

Behaviour:
- Clock is clk_in. Reset is rst_in: synchronous, active-high.
- Reset priority: rst_in, then the cycle after flush_out, then !rdy_in hold, then normal operation.
- Reset, or the cycle after flush_out:
  - all entries cleared; head = tail = count = 0.
  - every registered output returns to 0.
- Allocation:
  - Occurs only when inst_req && !full_out, using count before this cycle's commits; inst_req while full is dropped.
  - The entry is written busy=1, ready=0; tail advances mod ROB_DEPTH.
- Writeback:
  - For each p with wb_valid[p], a busy entry wb_id[p] gets ready=1 and res=wb_val[p].
  - A writeback to a non-busy entry is ignored.
  - If two ports name the same ID, the higher port index wins.
- Commit:
  - Scan slots k = 0..COMMIT_W-1 at head+k. The scan stops at the first entry that is not busy or not ready, using state before this edge.
  - A branch or JALR entry terminates the group after itself.
  - Each retired entry: busy=0, commit_valid[k]=1 on the next cycle.
  - Per-kind commit values:
    - kind 0: commit_val = res, commit_rd = rd.
    - kind 1: commit_rd = 0.
    - kind 2 (branch): commit_rd = 0; br_ready=1, br_taken=res[0], br_correct=(res[0]==pred). On mismatch, flush_out=1 and flush_pc = taken ? pc+imm : pc+4, with 32-bit wrap.
    - kind 3 (JALR): commit_val = pc+4, commit_rd = rd; jalr_ready=1, jalr_addr = res.
  - head advances by the number retired, mod ROB_DEPTH.
  - Pulse outputs are 0 in cycles with no retirement.
- count update: count <= count + alloc - retired.
- Same-cycle cases:
  - Allocation and retirement in the same cycle are both legal.
  - A writeback in the same cycle as the scan does not make that entry retire until the next cycle.
- Lookup:
  - q_ready[j] = entry ready, OR any wb_valid[p] with wb_id[p]==q_id[j].
  - q_val comes from the bypassing port (highest index) when bypassing, otherwise from the stored res.
  - Non-busy IDs return q_ready=0 and q_val=0.
- Wrap-around: indices wrap mod ROB_DEPTH. Full vs empty is resolved by count, not by comparing head and tail.

Optional Feature:
ROB_STATS_EN.
- Defined:
  - stat_commits is a 32-bit counter that adds the number retired each cycle.
  - stat_mispred counts flush_out pulses.
  - Both counters wrap, clear on rst_in, and are not cleared by flush.
- Undefined: both ports are tied to 0 and no counter registers exist.

Test Plan:
- Allocate 3 kind-0 entries (rd = 5, 6, 7) and write back IDs 0, 1, 2 with 10, 20, 30 in one cycle (three wb_valid strobes, CDB_PORTS=3) -> next cycle commit_valid=2'b11, rd 5/6 with values 10/20; the following cycle slot 0 retires rd 7, value 30.
- Fill 16 entries -> full_out=1; a 17th inst_req is dropped and alloc_id_out stays 0. Retire 2 entries -> count=14 and full_out=0.
- Branch at pc 0x100, imm 0x40, pred=0, wb_val=1 -> br_ready=1, br_correct=0, flush_out=1, flush_pc=0x140. Next cycle head=tail=0 and empty_out=1.
- JALR at pc 0x200, rd=1, wb_val=0x3000, followed by a ready kind-0 entry -> jalr_ready=1, jalr_addr=0x3000, commit_val=0x204; the younger entry does not retire in the same cycle.
- q_id=3 while wb port 1 writes ID 3 with 0xABCD -> q_ready=1 and q_val=0xABCD in the same cycle.
- rdy_in low for 3 cycles while entries are ready -> no commit pulses and all indices hold. With ROB_STATS_EN defined, stat_commits totals match the retired entries.
